// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the CPU memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
  localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;
  localparam logic [7:0]  UNMAPPED_RD  = 8'hFF;

  // RAM occupies 0 .. 2**aw-1 at the bottom of the 64 KiB map.
  function automatic logic in_ram(input logic [15:0] a, input int aw);
    return ({1'b0, a} < (17'd1 << aw));
  endfunction

  // ROM occupies the top 2**aw bytes, ending at 0xFFFF.
  function automatic logic in_rom(input logic [15:0] a, input int aw);
    return ({1'b0, a} >= (17'h10000 - (17'd1 << aw)));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response and load-port signals between a bus master and the responder.
interface mem_responder_if;

  logic        req;
  logic        rw;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdy;
  logic        err;
  logic        ld_valid;
  logic        ld_sel;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;

  modport master (
    output req, rw, address, wdata, ld_valid, ld_sel, ld_addr, ld_data,
    input  rdata, rdy, err, ld_ready
  );

  modport slave (
    input  req, rw, address, wdata, ld_valid, ld_sel, ld_addr, ld_data,
    output rdata, rdy, err, ld_ready
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port byte array: synchronous write, combinational read on the same address.
// Contents are deliberately not reset.
module mem_responder_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wd,
  output logic [7:0]    q
);

  logic [7:0] mem_r [0:(1 << AW) - 1];

  // Commit a byte on the write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wd;
    end
  end

  assign q = mem_r[addr];

endmodule

// File: rtl/mem_responder.sv
// CPU memory responder: decodes requests into RAM/ROM, inserts programmable wait
// states, pulses rdy on completion and accepts preload bytes through a side load port.
module mem_responder #(
  parameter int RAM_AW      = 12,
  parameter int ROM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic           ph2,
  input  logic           reset,
  mem_responder_if.slave bus
);

  import mem_responder_pkg::*;

  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  if ((17'd1 << RAM_AW) > (17'h10000 - (17'd1 << ROM_AW))) begin : g_overlap_chk
    $error("mem_responder: RAM and ROM address ranges overlap");
  end
  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_wait_chk
    $error("mem_responder: WAIT_STATES must be 0..15");
  end

  mem_state_t        state_r, next_state_s;
  logic [15:0]       addr_r;
  logic              rw_r;
  logic [7:0]        wdata_r;
  logic [3:0]        wait_cnt_r;
  logic [7:0]        rdata_r;
  logic              rdy_r;
  logic              err_r;

  logic              is_ram_s, is_rom_s;
  logic              ld_ready_s, ld_fire_s;
  logic              ram_we_s, rom_we_s;
  logic [RAM_AW-1:0] ram_addr_s;
  logic [ROM_AW-1:0] rom_addr_s;
  logic [7:0]        ram_wd_s, ram_q_s, rom_q_s;
  logic              unused_ld_addr_s;

  // Region decode of the latched CPU address.
  always_comb begin
    is_ram_s = in_ram(addr_r, RAM_AW);
    is_rom_s = in_rom(addr_r, ROM_AW);
  end

  // Load port is open only while idle with no CPU request; the CPU wins ties.
  assign ld_ready_s       = (state_r == IDLE) && !bus.req && reset;
  assign ld_fire_s        = bus.ld_valid && ld_ready_s;
  assign unused_ld_addr_s = ^bus.ld_addr;

  // Write-port muxes: load port while idle, CPU write commit only in RESP.
  always_comb begin
    ram_addr_s = addr_r[RAM_AW-1:0];
    ram_wd_s   = wdata_r;
    ram_we_s   = 1'b0;
    rom_addr_s = addr_r[ROM_AW-1:0];
    rom_we_s   = 1'b0;
    if (ld_fire_s && !bus.ld_sel) begin
      ram_addr_s = bus.ld_addr[RAM_AW-1:0];
      ram_wd_s   = bus.ld_data;
      ram_we_s   = 1'b1;
    end else if ((state_r == RESP) && !rw_r && is_ram_s) begin
      ram_we_s   = 1'b1;
    end else begin
      ram_we_s   = 1'b0;
    end
    if (ld_fire_s && bus.ld_sel) begin
      rom_addr_s = bus.ld_addr[ROM_AW-1:0];
      rom_we_s   = 1'b1;
    end else begin
      rom_we_s   = 1'b0;
    end
  end

  mem_responder_array #(.AW(RAM_AW)) u_ram (
    .clk  (ph2),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .wd   (ram_wd_s),
    .q    (ram_q_s)
  );

  mem_responder_array #(.AW(ROM_AW)) u_rom (
    .clk  (ph2),
    .we   (rom_we_s),
    .addr (rom_addr_s),
    .wd   (bus.ld_data),
    .q    (rom_q_s)
  );

  // FSM state register.
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state: optional wait phase, abort on req drop, single RESP cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          next_state_s = HAS_WAIT ? WAIT : RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (!bus.req) begin
          next_state_s = IDLE;
        end else if (wait_cnt_r == 4'd0) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latch, wait counter and registered response outputs.
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      addr_r     <= 16'h0000;
      rw_r       <= 1'b1;
      wdata_r    <= 8'h00;
      wait_cnt_r <= 4'd0;
      rdata_r    <= 8'h00;
      rdy_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req) begin
            addr_r     <= bus.address;
            rw_r       <= bus.rw;
            wdata_r    <= bus.wdata;
            wait_cnt_r <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt_r != 4'd0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        RESP: begin
          rdy_r <= 1'b1;
          if (rw_r) begin
            rdata_r <= is_ram_s ? ram_q_s : (is_rom_s ? rom_q_s : UNMAPPED_RD);
          end
          if ((!is_ram_s && !is_rom_s) || (!rw_r && is_rom_s)) begin
            err_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rdata    = rdata_r;
  assign bus.rdy      = rdy_r;
  assign bus.err      = err_r;
  assign bus.ld_ready = ld_ready_s;

endmodule
